// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and small helpers shared by the
// sync generator and its pixel divider.
package vga_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;

    localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int DEF_HS_START = DEF_H_VISIBLE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC - 1;
    localparam int DEF_VS_START = DEF_V_VISIBLE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC - 1;

    // Inclusive window test used for the active-low sync pulses.
    function automatic logic in_window(input logic [CNT_W-1:0] val,
                                       input int lo, input int hi);
        return (int'(val) >= lo) && (int'(val) <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Board-clock divider: PIXEL_TICK marks the last board clock of each pixel.
module pixel_tick_div #(
    parameter int CLK_DIV = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic PIXEL_TICK
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div <= '0;
        end else if (div == DIV_LAST) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // With CLK_DIV=1 div never leaves 0, so the tick is permanently high.
    assign PIXEL_TICK = (div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate h/v counters with registered sync and
// visible-area flags that always line up with PIXEL_X/PIXEL_Y.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic             CLK,
    input  logic             RESET_N,
    output logic             HSYNC,
    output logic             VSYNC,
    output logic             H_ON,
    output logic             V_ON,
    output logic [CNT_W-1:0] PIXEL_X,
    output logic [CNT_W-1:0] PIXEL_Y,
    output logic             PIXEL_TICK,
    output logic             FRAME_END
);

    localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VISIBLE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VISIBLE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

    logic             tick;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] v;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;

    pixel_tick_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .PIXEL_TICK (tick)
    );

    always_comb begin
        h_next = h;
        v_next = v;
        if (tick) begin
            if (h == H_LAST) begin
                h_next = '0;
                v_next = (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h_next = h + 1'b1;
            end
        end
    end

    // Flags decode the next counts so they update on the same edge as h/v.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            h     <= '0;
            v     <= '0;
            HSYNC <= 1'b1;
            VSYNC <= 1'b1;
            H_ON  <= 1'b1;
            V_ON  <= 1'b1;
        end else begin
            h     <= h_next;
            v     <= v_next;
            HSYNC <= !in_window(h_next, HS_START, HS_END);
            VSYNC <= !in_window(v_next, VS_START, VS_END);
            H_ON  <= (int'(h_next) < H_VISIBLE);
            V_ON  <= (int'(v_next) < V_VISIBLE);
        end
    end

    assign PIXEL_X    = h;
    assign PIXEL_Y    = v;
    assign PIXEL_TICK = tick;
    assign FRAME_END  = tick && (h == H_LAST) && (v == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three parameterisations against an arithmetic
// timing model, plus frame/sync-width protocol checks on the small ones.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Default-sized instance
    logic d_hs, d_vs, d_hon, d_von, d_tick, d_fe;
    logic [9:0] d_x, d_y;
    // Small frame, CLK_DIV=3: H 8/2/3/2 = 15, V 6/1/2/2 = 11
    logic a_hs, a_vs, a_hon, a_von, a_tick, a_fe;
    logic [9:0] a_x, a_y;
    // CLK_DIV=1 variant: H 4/2/2/2 = 10, V 3/1/1/1 = 6
    logic b_hs, b_vs, b_hon, b_von, b_tick, b_fe;
    logic [9:0] b_x, b_y;

    vga_sync_gen u_def (
        .CLK(clk), .RESET_N(rst_n), .HSYNC(d_hs), .VSYNC(d_vs), .H_ON(d_hon),
        .V_ON(d_von), .PIXEL_X(d_x), .PIXEL_Y(d_y), .PIXEL_TICK(d_tick),
        .FRAME_END(d_fe)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_a (
        .CLK(clk), .RESET_N(rst_n), .HSYNC(a_hs), .VSYNC(a_vs), .H_ON(a_hon),
        .V_ON(a_von), .PIXEL_X(a_x), .PIXEL_Y(a_y), .PIXEL_TICK(a_tick),
        .FRAME_END(a_fe)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_VISIBLE(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_b (
        .CLK(clk), .RESET_N(rst_n), .HSYNC(b_hs), .VSYNC(b_vs), .H_ON(b_hon),
        .V_ON(b_von), .PIXEL_X(b_x), .PIXEL_Y(b_y), .PIXEL_TICK(b_tick),
        .FRAME_END(b_fe)
    );

    logic [25:0] got_d, got_a, got_b;
    assign got_d = {d_hs, d_vs, d_hon, d_von, d_x, d_y, d_tick, d_fe};
    assign got_a = {a_hs, a_vs, a_hon, a_von, a_x, a_y, a_tick, a_fe};
    assign got_b = {b_hs, b_vs, b_hon, b_von, b_x, b_y, b_tick, b_fe};

    logic [25:0] exp_d[$];
    logic [25:0] exp_a[$];
    logic [25:0] exp_b[$];
    int total = 0;
    int bad   = 0;
    int n     = 0;

    // Outputs after n pixel-clock edges since reset release, from the raster rules.
    function automatic logic [25:0] model(input int n_edges, input int cd,
                                          input int hv, input int hfp, input int hs, input int hbp,
                                          input int vv, input int vfp, input int vs, input int vbp);
        int ht, vt, p, h, v;
        logic tick, hsync, vsync, hon, von, fe;
        ht    = hv + hfp + hs + hbp;
        vt    = vv + vfp + vs + vbp;
        p     = n_edges / cd;
        h     = p % ht;
        v     = (p / ht) % vt;
        tick  = ((n_edges % cd) == cd - 1);
        hsync = !((h >= hv + hfp) && (h < hv + hfp + hs));
        vsync = !((v >= vv + vfp) && (v < vv + vfp + vs));
        hon   = (h < hv);
        von   = (v < vv);
        fe    = tick && (h == ht - 1) && (v == vt - 1);
        return {hsync, vsync, hon, von, 10'(h), 10'(v), tick, fe};
    endfunction

    function automatic logic [25:0] model_a(input int n_edges);
        return model(n_edges, 3, 8, 2, 3, 2, 6, 1, 2, 2);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    // Driver: one board clock per call; reset is changed 1 ns after the edge.
    task automatic step(input logic rst_next);
        @(posedge clk);
        if (rst_n) n++;
        #1;
        rst_n = rst_next;
        if (!rst_n) n = 0;
        exp_d.push_back(model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        exp_a.push_back(model_a(n));
        exp_b.push_back(model(n, 1, 4, 2, 2, 2, 3, 1, 1, 1));
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (exp_d.size() > 0) check("def_outputs", {6'd0, got_d}, {6'd0, exp_d.pop_front()});
        if (exp_a.size() > 0) check("a_outputs", {6'd0, got_a}, {6'd0, exp_a.pop_front()});
        if (exp_b.size() > 0) check("b_outputs", {6'd0, got_b}, {6'd0, exp_b.pop_front()});
    end

    // Protocol checks: visible-pixel count, frame period and sync pulse widths.
    int a_vis, a_clks, a_hs_run, a_vs_run, d_hs_run;
    always @(negedge clk) begin
        if (!rst_n) begin
            a_vis = 0; a_clks = 0; a_hs_run = 0; a_vs_run = 0; d_hs_run = 0;
        end else begin
            a_clks++;
            if (a_tick && a_hon && a_von) a_vis++;
            if (a_fe) begin
                check("a_visible_pixels", a_vis, 48);
                check("a_frame_period", a_clks, 495);
                a_vis = 0;
                a_clks = 0;
            end
            if (!a_hs) a_hs_run++;
            else if (a_hs_run != 0) begin
                check("a_hsync_width", a_hs_run, 9);
                a_hs_run = 0;
            end
            if (!a_vs) a_vs_run++;
            else if (a_vs_run != 0) begin
                check("a_vsync_width", a_vs_run, 90);
                a_vs_run = 0;
            end
            if (!d_hs) d_hs_run++;
            else if (d_hs_run != 0) begin
                check("def_hsync_width", d_hs_run, 384);
                d_hs_run = 0;
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        repeat (5) step(1'b0);
        repeat (4000) step(1'b1);

        // Reset the small raster while both of its syncs are low.
        found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            logic [25:0] m;
            m = model_a(n + 1);
            if (!m[25] && !m[24]) found = 1'b1;
            else step(1'b1);
        end
        check("a_reach_both_syncs_low", {31'd0, found}, 32'd1);
        repeat (2) step(1'b0);
        repeat (3000) step(1'b1);

        repeat (3) begin
            repeat ($urandom_range(50, 700)) step(1'b1);
            repeat ($urandom_range(1, 3)) step(1'b0);
        end
        repeat (1500) step(1'b1);

        @(negedge clk);
        #1;
        check("queues_drained", exp_d.size() + exp_a.size() + exp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA timing generator sitting directly upstream of the RGB colour stage. It divides the board clock into a pixel-rate enable, runs horizontal and vertical position counters, and drives HSYNC/VSYNC to the connector. It also supplies H_ON/V_ON visible-area flags to the colour stage, and PIXEL_X/PIXEL_Y to the character/font lookup that produces BIT_FUENTE.

## Interface
Parameters:
- CLK_DIV, 4: board clocks per pixel (100 MHz -> 25 MHz); legal range ≥1
- H_VISIBLE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_VISIBLE, 480: visible lines per frame
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines

Ports:
- CLK  in  1  board clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- HSYNC  out  1  horizontal sync, active low, registered
- VSYNC  out  1  vertical sync, active low, registered
- H_ON  out  1  high while the horizontal count is in the visible area, registered
- V_ON  out  1  high while the vertical count is in the visible area, registered
- PIXEL_X  out  10  current horizontal count, 0..H_TOTAL-1
- PIXEL_Y  out  10  current vertical count, 0..V_TOTAL-1
- PIXEL_TICK  out  1  one-clock enable marking the last clock of each pixel
- FRAME_END  out  1  one-clock pulse on the last clock of each frame

## Operation
- H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800.
- V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP = 525.
- Divider counter div cycles 0..CLK_DIV-1. PIXEL_TICK = (div == CLK_DIV-1), decoded combinationally from the register. With CLK_DIV=1, PIXEL_TICK is constantly 1 after reset.
- On each clock edge where PIXEL_TICK=1:
  - h increments.
  - If h == H_TOTAL-1, h wraps to 0 and v increments.
  - If v == V_TOTAL-1 at the same time, v also wraps to 0.
- Counters hold on all other edges.
- Sync windows, decoded from the next counter values and registered on the same edge as the counters, so they are always coherent with PIXEL_X/PIXEL_Y:
  - HSYNC=0 iff H_VISIBLE+H_FP ≤ h ≤ H_VISIBLE+H_FP+H_SYNC-1 (656..751).
  - VSYNC=0 iff V_VISIBLE+V_FP ≤ v ≤ V_VISIBLE+V_FP+V_SYNC-1 (490..491).
- Visible flags: H_ON = (h < H_VISIBLE); V_ON = (v < V_VISIBLE).
- FRAME_END = PIXEL_TICK & (h == H_TOTAL-1) & (v == V_TOTAL-1), combinational.
- All counter arithmetic is unsigned 10-bit; no counter ever exceeds TOTAL-1.
- Reset, asserted at any time including mid-line or mid-sync:
  - div, h and v go to 0.
  - HSYNC=1, VSYNC=1, H_ON=1, V_ON=1, PIXEL_X=0, PIXEL_Y=0, PIXEL_TICK=0 (or 1 when CLK_DIV=1), FRAME_END=0.
  - The first pixel after release is (0,0) and lasts a full CLK_DIV clocks.

## Timing
- Pixel period: CLK_DIV clocks. Line: 800 pixels = 3200 clocks. Frame: 525 lines = 1,680,000 clocks (16.8 ms at 100 MHz).
- Output latency: zero. HSYNC/VSYNC/H_ON/V_ON change on the same edge as PIXEL_X/PIXEL_Y.
- Downstream font lookup must register its result within one pixel period; the colour stage stays combinational.
- Wrap-around: h 799->0 and v increment occur on one edge. At (799,524) both counters wrap together and FRAME_END is high in the preceding clock.
- Reset is asynchronous on assertion. Deassertion is synchronised externally and is not handled in this block.

## Structure
- Package vga_timing_pkg holds:
  - the default porch/sync/visible constants;
  - derived H_TOTAL/V_TOTAL;
  - sync start/end constants;
  - counter width (10).
- Sub-module pixel_tick_div: CLK_DIV counter producing PIXEL_TICK, with the same CLK/RESET_N.
- h/v counters and output decode live in the top module.

## Test plan
- Reset: hold RESET_N=0 for 50 ns -> HSYNC=VSYNC=H_ON=V_ON=1, PIXEL_X=PIXEL_Y=0, PIXEL_TICK=0. After release, first PIXEL_TICK at clock 4.
- Line timing:
  - H_ON falls when PIXEL_X goes 639->640.
  - HSYNC low from PIXEL_X=656 through 751 (384 clocks).
  - PIXEL_X wraps 799->0 with PIXEL_Y +1 on the same edge.
- Frame timing:
  - V_ON falls at PIXEL_Y=480.
  - VSYNC low only for PIXEL_Y 490..491 (6400 clocks).
  - FRAME_END high exactly once per 1,680,000 clocks, at (799,524).
- Mid-operation reset: assert RESET_N=0 at PIXEL_X=700, PIXEL_Y=491 (both syncs low) -> HSYNC and VSYNC return to 1 immediately and counters read 0,0.
- Parameter variant: CLK_DIV=1 with H_TOTAL=10 (VISIBLE 4, FP 2, SYNC 2, BP 2) -> PIXEL_TICK constant 1, HSYNC low for h=6..7, line period 10 clocks.
- Continuous run of 2 frames -> protocol checker confirms:
  - H_ON&V_ON covers exactly 307,200 pixels per frame;
  - no sync glitch shorter than its programmed width.
